// File: rtl/quad_updown_cmd_gen_pkg.sv
// Shared encodings for the quadrature command generator and the updown_counter it feeds.
// Holds the up_down command codes, the decoder FSM states and the Gray-order helper.
package quad_updown_cmd_gen_pkg;

   typedef enum logic [1:0] {
      UD_HOLD = 2'b00,
      UD_UP   = 2'b01,
      UD_DOWN = 2'b10
   } ud_cmd_t;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } quad_state_t;

   // Successor of {A,B} when moving in the UP direction: 00->10->11->01->00.
   function automatic logic [1:0] gray_next_up(input logic [1:0] ab);
      logic [1:0] nxt;
      case (ab)
         2'b00:   nxt = 2'b10;
         2'b10:   nxt = 2'b11;
         2'b11:   nxt = 2'b01;
         default: nxt = 2'b00;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/quad_updown_cmd_gen_if.sv
// Bus between the encoder-side controls and the quadrature command generator.
// master drives the encoder pins and controls; slave is the generator.
interface quad_updown_cmd_gen_if #(
   parameter int ERR_CNT_W = 8
);
   logic                 en;
   logic                 quad_a;
   logic                 quad_b;
   logic                 clr_err;
   logic [1:0]           up_down;
   logic                 dir;
   logic                 err;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport master (
      output en, quad_a, quad_b, clr_err,
      input  up_down, dir, err, err_cnt
   );

   modport slave (
      input  en, quad_a, quad_b, clr_err,
      output up_down, dir, err, err_cnt
   );
endinterface

// File: rtl/quad_updown_cmd_gen_glitch_filter.sv
// Two-flop synchroniser plus stability filter for one asynchronous encoder channel.
// filt only follows the input after FILT_LEN consecutive edges of disagreement.
module quad_glitch_filter #(
   parameter int FILT_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic filt
);
   localparam int CNT_W = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         filt <= 1'b0;
         cnt  <= '0;
      end else begin
         s1 <= din;
         s2 <= s1;
         if (s2 == filt) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
            filt <= s2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/quad_updown_cmd_gen.sv
// Quadrature decoder producing one-cycle UP/DOWN commands for updown_counter,
// with illegal-transition detection and a saturating error count.
module quad_updown_cmd_gen
   import quad_updown_cmd_gen_pkg::*;
#(
   parameter int FILT_LEN  = 4,
   parameter int ERR_CNT_W = 8
) (
   input logic                 clk,
   input logic                 reset,
   quad_updown_cmd_gen_if.slave bus
);
   logic                 filt_a;
   logic                 filt_b;
   logic [1:0]           ab;
   logic [1:0]           prev;
   quad_state_t          state;
   ud_cmd_t              up_down_q;
   logic                 dir_q;
   logic                 err_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic                 step_up;
   logic                 step_down;
   logic                 illegal;

   quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
      .clk(clk), .reset(reset), .din(bus.quad_a), .filt(filt_a)
   );

   quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
      .clk(clk), .reset(reset), .din(bus.quad_b), .filt(filt_b)
   );

   assign ab = {filt_a, filt_b};

   // Anything in TRACK that moved but is neither Gray neighbour changed both bits at once.
   always_comb begin
      step_up   = 1'b0;
      step_down = 1'b0;
      illegal   = 1'b0;
      if (state == ST_TRACK && ab != prev) begin
         step_up   = (ab == gray_next_up(prev));
         step_down = (prev == gray_next_up(ab));
         illegal   = !step_up && !step_down;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_INIT;
         prev      <= 2'b00;
         up_down_q <= UD_HOLD;
         dir_q     <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         up_down_q <= UD_HOLD;
         err_q     <= illegal;

         case (state)
            ST_INIT: begin
               if (ab != prev) begin
                  prev  <= ab;
                  state <= ST_TRACK;
               end
            end
            default: begin
               prev <= ab;
               if (step_up) begin
                  dir_q <= 1'b1;
                  if (bus.en) up_down_q <= UD_UP;
               end else if (step_down) begin
                  dir_q <= 1'b0;
                  if (bus.en) up_down_q <= UD_DOWN;
               end
            end
         endcase

         if (bus.clr_err) begin
            err_cnt_q <= illegal ? ERR_CNT_W'(1) : '0;
         end else if (illegal && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
         end
      end
   end

   assign bus.up_down = up_down_q;
   assign bus.dir     = dir_q;
   assign bus.err     = err_q;
   assign bus.err_cnt = err_cnt_q;
endmodule
